// File: rtl/rob_commit_stage.sv
// Reorder buffer with in-order retirement: entries are allocated at the tail and completed out of order
// by ALU writebacks. The head entry retires as a register-file commit, or as an exception that flushes the buffer.
module rob_commit_stage #(
  parameter int ROB_DEPTH = 8,
  parameter int TAG_W     = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alloc_valid,
  output logic [TAG_W-1:0] tail_rob,
  output logic             rob_full,
  input  logic             wb_valid,
  input  logic [TAG_W-1:0] wb_tag,
  input  logic [15:0]      wb_data,
  input  logic [2:0]       wb_destReg,
  input  logic             wb_we,
  input  logic [1:0]       wb_ex_vector,
  input  logic [15:0]      wb_pc,
  output logic             commit_valid,
  output logic [2:0]       commit_destReg,
  output logic [15:0]      commit_data,
  output logic             commit_we,
  output logic             exception_valid,
  output logic [1:0]       exception_vector,
  output logic [15:0]      exception_pc,
  output logic             flush
);

  localparam logic [TAG_W:0] CNT_FULL = (TAG_W+1)'(ROB_DEPTH);

  logic [TAG_W-1:0]     head_q, head_d, tail_q, tail_d;
  logic [TAG_W:0]       count_q, count_d;
  logic [ROB_DEPTH-1:0] busy_q, done_q;
  logic [15:0]          data_q  [ROB_DEPTH];
  logic [15:0]          pc_q    [ROB_DEPTH];
  logic [2:0]           dest_q  [ROB_DEPTH];
  logic [1:0]           ex_q    [ROB_DEPTH];
  logic [ROB_DEPTH-1:0] we_q;

  logic head_ready, do_commit, do_flush, do_alloc;

  assign tail_rob = tail_q;
  assign rob_full = (count_q == CNT_FULL);

  always_comb begin
    head_ready = busy_q[head_q] & done_q[head_q];
    do_commit  = head_ready & (ex_q[head_q] == 2'b00);
    do_flush   = head_ready & (ex_q[head_q] != 2'b00);
    do_alloc   = alloc_valid & ~rob_full;
    head_d     = do_commit ? head_q + TAG_W'(1) : head_q;
    tail_d     = do_alloc  ? tail_q + TAG_W'(1) : tail_q;
    count_d    = count_q;
    if (do_alloc && !do_commit)      count_d = count_q + 1'b1;
    else if (!do_alloc && do_commit) count_d = count_q - 1'b1;
  end

  // Payload fields need no reset: they are only read once busy and done have been set again.
  always_ff @(posedge clk) begin
    if (wb_valid && busy_q[wb_tag]) begin
      data_q[wb_tag] <= wb_data;
      pc_q[wb_tag]   <= wb_pc;
      dest_q[wb_tag] <= wb_destReg;
      ex_q[wb_tag]   <= wb_ex_vector;
      we_q[wb_tag]   <= wb_we;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q           <= '0;
      tail_q           <= '0;
      count_q          <= '0;
      busy_q           <= '0;
      done_q           <= '0;
      commit_valid     <= 1'b0;
      commit_destReg   <= '0;
      commit_data      <= '0;
      commit_we        <= 1'b0;
      exception_valid  <= 1'b0;
      exception_vector <= '0;
      exception_pc     <= '0;
      flush            <= 1'b0;
    end else begin
      commit_valid     <= do_commit;
      commit_destReg   <= do_commit ? dest_q[head_q] : 3'd0;
      commit_data      <= do_commit ? data_q[head_q] : 16'd0;
      commit_we        <= do_commit & we_q[head_q];
      exception_valid  <= do_flush;
      flush            <= do_flush;
      exception_vector <= do_flush ? ex_q[head_q] : 2'b00;
      exception_pc     <= do_flush ? pc_q[head_q] : 16'd0;
      // An exception at the head wipes the buffer and discards this cycle's alloc and writeback.
      if (do_flush) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
        busy_q  <= '0;
        done_q  <= '0;
      end else begin
        head_q  <= head_d;
        tail_q  <= tail_d;
        count_q <= count_d;
        if (wb_valid && busy_q[wb_tag]) done_q[wb_tag] <= 1'b1;
        if (do_commit) busy_q[head_q] <= 1'b0;
        if (do_alloc) begin
          busy_q[tail_q] <= 1'b1;
          done_q[tail_q] <= 1'b0;
        end
      end
    end
  end

endmodule
